// File: rtl/rcs_pkg.sv
// Shared types and default sizing for the multi-precision subtract sequencer.
package rcs_pkg;

  localparam int unsigned G_DEF = 32;
  localparam int unsigned N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rcs_mp_seq_if.sv
// Request/response bundle between a client and the multi-precision subtract sequencer.
interface rcs_mp_seq_if
  import rcs_pkg::*;
#(
  parameter int unsigned G = G_DEF,
  parameter int unsigned N = N_DEF
);

  localparam int unsigned W = G * N;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff_o;
  logic         bout_o;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff_o, bout_o
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff_o, bout_o
  );

endinterface

// File: rtl/rcs.sv
// G-bit ripple-borrow subtractor: {bout, diff} = a - b - bin.
module rcs #(
  parameter int unsigned G = 32
) (
  input  logic [G-1:0] a,
  input  logic [G-1:0] b,
  input  logic         bin,
  output logic [G-1:0] diff,
  output logic         bout
);

  always_comb begin
    logic c;
    c    = bin;
    diff = '0;
    for (int i = 0; i < int'(G); i++) begin
      diff[i] = a[i] ^ b[i] ^ c;
      c       = (~a[i] & (b[i] | c)) | (b[i] & c);
    end
    bout = c;
  end

endmodule

// File: rtl/rcs_mp_seq.sv
// Sequences an N-word subtraction through an external G-bit rcs, LS word first,
// rippling the borrow word to word and assembling the full difference.
module rcs_mp_seq
  import rcs_pkg::*;
#(
  parameter int unsigned G  = G_DEF,
  parameter int unsigned N  = N_DEF,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  rcs_mp_seq_if.slave   bus,
  output logic [G-1:0]  sub_a,
  output logic [G-1:0]  sub_b,
  output logic          sub_bin,
  input  logic [G-1:0]  sub_diff,
  input  logic          sub_bout
);

  localparam int unsigned W = G * N;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  a_q,     a_d;
  logic [W-1:0]  b_q,     b_d;
  logic [W-1:0]  diff_q,  diff_d;
  logic          bout_q,  bout_d;
  logic          done_q;
  logic          busy_q;

  // Next-state, datapath updates and the combinational feed to rcs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    sub_a    = '0;
    sub_b    = '0;
    sub_bin  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sub_a    = a_q[idx_q*G +: G];
        sub_b    = b_q[idx_q*G +: G];
        sub_bin  = borrow_q;
        diff_d[idx_q*G +: G] = sub_diff;
        borrow_d = sub_bout;
        idx_d    = IW'(idx_q + 1'b1);
        if (idx_q == IW'(N - 1)) begin
          bout_d  = sub_bout;
          state_d = DONE;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; done/busy are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff_o = diff_q;
  assign bus.bout_o = bout_q;

endmodule

// File: doc/rcs_mp_seq.md
Name: rcs_mp_seq

Overview:
- Multi-precision subtract sequencer that sits directly upstream of the G-bit ripple-carry subtractor `rcs`.
- Accepts N-word operands with a start pulse and drives `rcs` one G-bit word per cycle, least-significant word first.
- Chains each word's `bout` into the next word's `bin`.
- Assembles the full G*N-bit difference and final borrow, then signals completion with a one-cycle done pulse.

Parameters:
- G, 32, word width; must equal the G of the attached `rcs`.
- N, 4, number of words per operand; N >= 2.
- IW, $clog2(N), width of the word index.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; accepted only in IDLE.
- a  input  G*N  minuend; sampled on the accepting edge.
- b  input  G*N  subtrahend; sampled on the accepting edge.
- bin  input  1  initial borrow-in; sampled on the accepting edge.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; diff_o and bout_o are valid.
- diff_o  output  G*N  a - b - bin, modulo 2^(G*N).
- bout_o  output  1  final borrow-out (1 when a < b + bin).
- sub_a  output  G  to rcs.a.
- sub_b  output  G  to rcs.b.
- sub_bin  output  1  to rcs.bin.
- sub_diff  input  G  from rcs.diff.
- sub_bout  input  1  from rcs.bout.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; idx=0; borrow=0; a_r=b_r=0; diff_o=0; bout_o=0; done=0. busy is 0 the cycle after reset. rst overrides start and any in-flight operation. A partial result is discarded; diff_o is zeroed, not left partial.
- States: IDLE, RUN, DONE.
- IDLE:
  - sub_a=0, sub_b=0, sub_bin=0.
  - When start=1: a_r<=a, b_r<=b, borrow<=bin, idx<=0, go to RUN.
  - diff_o and bout_o hold their previous values until overwritten.
- RUN:
  - sub_a=a_r[idx*G +: G], sub_b=b_r[idx*G +: G], sub_bin=borrow. These are driven combinationally from registers; the rcs path must settle within one cycle.
  - Each edge: diff_o[idx*G +: G]<=sub_diff, borrow<=sub_bout, idx<=idx+1.
  - When idx==N-1, go to DONE and latch bout_o<=sub_bout in the same edge.
- DONE: done=1 for exactly one cycle; idx<=0; go to IDLE. start is ignored in this cycle.
- start while busy (RUN or DONE) is ignored and not queued. a/b/bin changing during RUN has no effect.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+N. That is N+1 cycles from acceptance to the done cycle.
- Throughput: a new start is accepted at the earliest on the edge where done is high is leaving. That means the cycle after done, giving one result per N+2 cycles.
- The borrow chain is exactly the N-word ripple: no word may be skipped, even when operand words are zero.
- All arithmetic is unsigned and modulo. No overflow flag exists beyond bout_o.
- Outputs are registered except sub_a, sub_b and sub_bin.

Decomposition:
- Shared package rcs_pkg:
  - typedef state_t {IDLE, RUN, DONE}
  - localparams for default G and N
- No sub-module inside this block. The subtractor stays external so `rcs` can be reused unchanged.
- The top-level and bench instantiate `rcs` next to rcs_mp_seq and wire sub_* to it.
- The word-slice select is a simple indexed part-select and is not split out.

Test Plan:
- G=32, N=4, a=15, b=7, bin=1, start → done after 5 cycles; diff_o=7; bout_o=0; sub_bin sequence 1,0,0,0.
- a=0, b=1, bin=0 → diff_o=2^128-1 (all ones); bout_o=1; sub_bout=1 on all four word cycles.
- a=2^32, b=1, bin=0 → diff_o=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF; bout_o=0; borrow seen only between word 0 and word 1.
- start pulsed again in the 2nd RUN cycle with different operands → ignored; first result is unchanged. A start the cycle after done is accepted, and its result appears N+1 cycles later.
- rst asserted during the 3rd RUN cycle → next cycle busy=0, done=0, diff_o=0, bout_o=0, sub_a=sub_b=0. A following start completes correctly.
- Random soak: 10 runs with a and b random 128-bit values and bin random → diff_o/bout_o match a reference of {bout,diff}=a-b-bin. Input and output values are logged to input.txt and output.txt.
